// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // EX operand source selects
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // $zero never produces a hazard or a forward
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Data-memory handshake states
  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } dmem_state_t;

endpackage

// File: rtl/pipe_ctrl_dmem_fsm.sv
// Data-memory req/ack sequencer with a sticky wait-timeout flag.
module pipe_ctrl_dmem_fsm #(
  parameter int DMEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_acc,
  input  logic dmem_ack,
  output logic dmem_req,
  output logic dmem_stall,
  output logic dmem_timeout
);
  import pipe_ctrl_pkg::*;

  dmem_state_t state;
  logic [7:0]  tmo_cnt;

  // Handshake state, wait-cycle counter and sticky timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= M_IDLE;
      tmo_cnt      <= '0;
      dmem_timeout <= 1'b0;
    end else begin
      case (state)
        M_IDLE: begin
          if (mem_acc && !dmem_ack) state <= M_WAIT;
        end
        M_WAIT: begin
          if (dmem_ack) begin
            state   <= M_IDLE;
            tmo_cnt <= '0;
          end else begin
            if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 8'd1;
            if (({1'b0, tmo_cnt} + 9'd1) >= 9'(DMEM_TIMEOUT)) dmem_timeout <= 1'b1;
          end
        end
        default: state <= M_IDLE;
      endcase
    end
  end

  // Request and stall are combinational and forced low during reset
  always_comb begin
    dmem_req   = reset & ((state == M_WAIT) | mem_acc);
    dmem_stall = reset & mem_acc & ~dmem_ack;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/forwarding controller for the 5-stage pipeline.
module pipe_hazard_ctrl #(
  parameter int MDU_LAT      = 4,
  parameter int DMEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       ex_valid_i,
  input  logic [4:0] ex_rs_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_reg_wr_i,
  input  logic       ex_mem_to_reg_i,
  input  logic       ex_mdu_op_i,
  input  logic       ex_branch_taken_i,
  input  logic       mem_valid_i,
  input  logic       mem_reg_wr_i,
  input  logic       mem_mem_to_reg_i,
  input  logic       mem_mem_wr_i,
  input  logic [4:0] mem_rd_i,
  input  logic       wb_valid_i,
  input  logic       wb_reg_wr_i,
  input  logic [4:0] wb_rd_i,
  input  logic       dmem_ack_i,
  output logic       dmem_req_o,
  output logic       stall_if_o,
  output logic       stall_id_o,
  output logic       stall_ex_o,
  output logic       stall_mem_o,
  output logic       clr_id_o,
  output logic       clr_ex_o,
  output logic       clr_mem_o,
  output logic       clr_wb_o,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o,
  output logic       mdu_busy_o,
  output logic       dmem_timeout_o
);
  import pipe_ctrl_pkg::*;

  localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;

  logic          mem_acc;
  logic          dmem_stall;
  logic [CW-1:0] mdu_cnt;
  logic          mdu_start;
  logic          mdu_stall;
  logic          load_use;
  logic          br_flush;

  assign mem_acc = mem_valid_i & (mem_mem_to_reg_i | mem_mem_wr_i);

  pipe_ctrl_dmem_fsm #(
    .DMEM_TIMEOUT(DMEM_TIMEOUT)
  ) u_dmem (
    .clk          (clk),
    .reset        (reset),
    .mem_acc      (mem_acc),
    .dmem_ack     (dmem_ack_i),
    .dmem_req     (dmem_req_o),
    .dmem_stall   (dmem_stall),
    .dmem_timeout (dmem_timeout_o)
  );

  // MDU occupancy counter; a memory stall freezes it, including at the
  // final count, so a held MDU op in EX cannot restart.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdu_cnt <= '0;
    end else if (!dmem_stall) begin
      if (mdu_start)            mdu_cnt <= CW'(MDU_LAT - 1);
      else if (mdu_cnt != '0)   mdu_cnt <= mdu_cnt - CW'(1);
    end
  end

  // Hazard detection terms
  always_comb begin
    mdu_start  = ex_valid_i & ex_mdu_op_i & (mdu_cnt == '0) & ~dmem_stall & (MDU_LAT > 1);
    mdu_stall  = reset & (mdu_start | (mdu_cnt > CW'(1)));
    mdu_busy_o = reset & (mdu_stall | (mdu_cnt == CW'(1)));
    load_use   = ex_valid_i & ex_mem_to_reg_i & ex_reg_wr_i & (ex_rd_i != REG_ZERO) &
                 id_valid_i & ((ex_rd_i == id_rs_i) | (ex_rd_i == id_rt_i));
    br_flush   = ex_valid_i & ex_branch_taken_i;
  end

  // Prioritised stall/bubble generation, all low in reset
  always_comb begin
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    stall_ex_o  = 1'b0;
    stall_mem_o = 1'b0;
    clr_id_o    = 1'b0;
    clr_ex_o    = 1'b0;
    clr_mem_o   = 1'b0;
    clr_wb_o    = 1'b0;
    if (reset) begin
      if (dmem_stall) begin
        stall_if_o  = 1'b1;
        stall_id_o  = 1'b1;
        stall_ex_o  = 1'b1;
        stall_mem_o = 1'b1;
        clr_wb_o    = 1'b1;
      end else if (mdu_stall) begin
        stall_if_o = 1'b1;
        stall_id_o = 1'b1;
        stall_ex_o = 1'b1;
        clr_mem_o  = 1'b1;
      end else if (br_flush) begin
        clr_id_o = 1'b1;
        clr_ex_o = 1'b1;
      end else if (load_use) begin
        stall_if_o = 1'b1;
        stall_id_o = 1'b1;
        clr_ex_o   = 1'b1;
      end
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (mem_valid_i && mem_reg_wr_i && !mem_mem_to_reg_i && mem_rd_i != REG_ZERO && mem_rd_i == src)
      return FWD_MEM;
    else if (wb_valid_i && wb_reg_wr_i && wb_rd_i != REG_ZERO && wb_rd_i == src)
      return FWD_WB;
    else
      return FWD_REG;
  endfunction

  // EX operand forwarding selects, MEM before WB
  always_comb begin
    fwd_a_o = FWD_REG;
    fwd_b_o = FWD_REG;
    if (reset) begin
      fwd_a_o = fwd_sel(ex_rs_i);
      fwd_b_o = fwd_sel(ex_rt_i);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised + directed scoreboard bench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

  localparam int LAT = 4;
  localparam int TMO = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       id_valid, ex_valid, ex_reg_wr, ex_mem_to_reg, ex_mdu_op, ex_branch_taken;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       mem_valid, mem_reg_wr, mem_mem_to_reg, mem_mem_wr;
  logic       wb_valid, wb_reg_wr, dmem_ack;

  logic       dmem_req, st_if, st_id, st_ex, st_mem, c_id, c_ex, c_mem, c_wb, busy, tmo;
  logic [1:0] fa, fb;
  logic       dmem_req1, st_if1, st_id1, st_ex1, st_mem1, c_id1, c_ex1, c_mem1, c_wb1, busy1, tmo1;
  logic [1:0] fa1, fb1;

  pipe_hazard_ctrl #(.MDU_LAT(LAT), .DMEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .ex_valid_i(ex_valid), .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_rd_i(ex_rd),
    .ex_reg_wr_i(ex_reg_wr), .ex_mem_to_reg_i(ex_mem_to_reg), .ex_mdu_op_i(ex_mdu_op),
    .ex_branch_taken_i(ex_branch_taken),
    .mem_valid_i(mem_valid), .mem_reg_wr_i(mem_reg_wr), .mem_mem_to_reg_i(mem_mem_to_reg),
    .mem_mem_wr_i(mem_mem_wr), .mem_rd_i(mem_rd),
    .wb_valid_i(wb_valid), .wb_reg_wr_i(wb_reg_wr), .wb_rd_i(wb_rd),
    .dmem_ack_i(dmem_ack), .dmem_req_o(dmem_req),
    .stall_if_o(st_if), .stall_id_o(st_id), .stall_ex_o(st_ex), .stall_mem_o(st_mem),
    .clr_id_o(c_id), .clr_ex_o(c_ex), .clr_mem_o(c_mem), .clr_wb_o(c_wb),
    .fwd_a_o(fa), .fwd_b_o(fb), .mdu_busy_o(busy), .dmem_timeout_o(tmo)
  );

  // Single-cycle MDU variant: multiply ops must never stall
  pipe_hazard_ctrl #(.MDU_LAT(1), .DMEM_TIMEOUT(TMO)) dut_lat1 (
    .clk(clk), .reset(reset),
    .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .ex_valid_i(ex_valid), .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_rd_i(ex_rd),
    .ex_reg_wr_i(ex_reg_wr), .ex_mem_to_reg_i(ex_mem_to_reg), .ex_mdu_op_i(ex_mdu_op),
    .ex_branch_taken_i(ex_branch_taken),
    .mem_valid_i(mem_valid), .mem_reg_wr_i(mem_reg_wr), .mem_mem_to_reg_i(mem_mem_to_reg),
    .mem_mem_wr_i(mem_mem_wr), .mem_rd_i(mem_rd),
    .wb_valid_i(wb_valid), .wb_reg_wr_i(wb_reg_wr), .wb_rd_i(wb_rd),
    .dmem_ack_i(dmem_ack), .dmem_req_o(dmem_req1),
    .stall_if_o(st_if1), .stall_id_o(st_id1), .stall_ex_o(st_ex1), .stall_mem_o(st_mem1),
    .clr_id_o(c_id1), .clr_ex_o(c_ex1), .clr_mem_o(c_mem1), .clr_wb_o(c_wb1),
    .fwd_a_o(fa1), .fwd_b_o(fb1), .mdu_busy_o(busy1), .dmem_timeout_o(tmo1)
  );

  typedef struct {
    int         cyc;
    logic [3:0] stall;  // if,id,ex,mem
    logic [3:0] clr;    // id,ex,mem,wb
    logic [1:0] fa, fb;
    logic       req, busy, tmo;
    logic       stall_ex1, busy1;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;

  // Reference state, kept in terms of "what is the pipeline doing"
  bit waiting;      // a memory access is outstanding past its first cycle
  int wait_run;     // consecutive unacknowledged wait cycles
  bit tmo_flag;
  int mdu_done;     // EX cycles already spent by the current MDU op (0 = none)

  function automatic logic [1:0] exp_fwd(input logic [4:0] src);
    if (src != 0 && mem_valid && mem_reg_wr && !mem_mem_to_reg && mem_rd == src) return 2'b01;
    if (src != 0 && wb_valid && wb_reg_wr && wb_rd == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_step();
    exp_t e;
    bit   acc, dst, start, mst, br, lu;
    e.cyc = cyc;
    e.stall = 4'b0; e.clr = 4'b0; e.fa = 2'b00; e.fb = 2'b00;
    e.req = 1'b0; e.busy = 1'b0; e.tmo = 1'b0; e.stall_ex1 = 1'b0; e.busy1 = 1'b0;
    if (!reset) begin
      waiting = 0; wait_run = 0; tmo_flag = 0; mdu_done = 0;
      exp_q.push_back(e);
      return;
    end
    acc   = mem_valid && (mem_mem_to_reg || mem_mem_wr);
    dst   = acc && !dmem_ack;
    e.req = waiting || acc;
    e.tmo = tmo_flag;
    start = 0;
    mst   = 0;
    if (mdu_done > 0) begin
      mst    = (mdu_done + 1) < LAT;
      e.busy = 1;
    end else if (ex_valid && ex_mdu_op && !dst && LAT > 1) begin
      start  = 1;
      mst    = 1;
      e.busy = 1;
    end
    br = ex_valid && ex_branch_taken;
    lu = ex_valid && ex_mem_to_reg && ex_reg_wr && ex_rd != 0 && id_valid &&
         (ex_rd == id_rs || ex_rd == id_rt);
    if (dst)      begin e.stall = 4'b1111; e.clr = 4'b0001; end
    else if (mst) begin e.stall = 4'b1110; e.clr = 4'b0010; end
    else if (br)  begin e.clr = 4'b1100; end
    else if (lu)  begin e.stall = 4'b1100; e.clr = 4'b0100; end
    e.fa = exp_fwd(ex_rs);
    e.fb = exp_fwd(ex_rt);
    e.stall_ex1 = dst;
    exp_q.push_back(e);
    // advance to next cycle
    if (!dst && (mdu_done > 0 || start)) begin
      mdu_done++;
      if (mdu_done >= LAT) mdu_done = 0;
    end
    if (!waiting) begin
      if (dst) waiting = 1;
    end else if (dmem_ack) begin
      waiting = 0; wait_run = 0;
    end else begin
      wait_run++;
      if (wait_run >= TMO) tmo_flag = 1;
    end
  endtask

  task automatic check(input string name, input int c, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  // Monitor: compare the DUT against the oldest expectation mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall", e.cyc, {4'b0, st_if, st_id, st_ex, st_mem}, {4'b0, e.stall});
        check("clr",   e.cyc, {4'b0, c_id, c_ex, c_mem, c_wb}, {4'b0, e.clr});
        check("fwd",   e.cyc, {4'b0, fa, fb}, {4'b0, e.fa, e.fb});
        check("req_busy_tmo", e.cyc, {5'b0, dmem_req, busy, tmo}, {5'b0, e.req, e.busy, e.tmo});
        check("lat1_mdu", e.cyc, {6'b0, st_ex1, busy1}, {6'b0, e.stall_ex1, e.busy1});
      end
    end
  end

  task automatic idle_inputs();
    reset = 1'b1;
    id_valid = 0; id_rs = 0; id_rt = 0;
    ex_valid = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0;
    ex_reg_wr = 0; ex_mem_to_reg = 0; ex_mdu_op = 0; ex_branch_taken = 0;
    mem_valid = 0; mem_reg_wr = 0; mem_mem_to_reg = 0; mem_mem_wr = 0; mem_rd = 0;
    wb_valid = 0; wb_reg_wr = 0; wb_rd = 0; dmem_ack = 0;
  endtask

  // Record expectation for the current inputs, then move to next cycle
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_lw_in_ex(input logic [4:0] rd);
    ex_valid = 1; ex_mem_to_reg = 1; ex_reg_wr = 1; ex_rd = rd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b0;
    mem_valid = 1; mem_mem_wr = 1; ex_valid = 1; ex_mdu_op = 1;  // must be masked by reset
    @(posedge clk); #1;
    step(); step();
    idle_inputs(); step();

    // load-use on rs, then same with rd = $zero
    set_lw_in_ex(5'd5); id_valid = 1; id_rs = 5'd5; id_rt = 5'd7; step();
    idle_inputs(); step();
    set_lw_in_ex(5'd0); id_valid = 1; id_rs = 5'd0; id_rt = 5'd0; step();
    idle_inputs(); step();

    // taken branch outranks load-use
    set_lw_in_ex(5'd9); ex_branch_taken = 1; id_valid = 1; id_rt = 5'd9; step();
    idle_inputs(); step();

    // MDU op held in EX for its full latency
    for (int i = 0; i < LAT + 2; i++) begin
      idle_inputs();
      if (i < LAT) begin ex_valid = 1; ex_mdu_op = 1; end
      step();
    end

    // store with ack on the 4th cycle, then zero-wait store
    for (int i = 0; i < 4; i++) begin
      idle_inputs(); mem_valid = 1; mem_mem_wr = 1; dmem_ack = (i == 3); step();
    end
    idle_inputs(); mem_valid = 1; mem_mem_wr = 1; dmem_ack = 1; step();
    idle_inputs(); step();

    // forwarding: MEM beats WB; a load in MEM defers to WB
    idle_inputs(); ex_rs = 3; ex_rt = 4;
    mem_valid = 1; mem_reg_wr = 1; mem_rd = 3; dmem_ack = 1;
    wb_valid = 1; wb_reg_wr = 1; wb_rd = 3; step();
    mem_mem_to_reg = 1; step();
    idle_inputs(); ex_rs = 0; wb_valid = 1; wb_reg_wr = 1; wb_rd = 0; step();

    // timeout: long wait, late ack, flag stays set
    for (int i = 0; i < TMO + 6; i++) begin
      idle_inputs(); mem_valid = 1; mem_mem_to_reg = 1; dmem_ack = (i == TMO + 5); step();
    end
    for (int i = 0; i < 3; i++) begin idle_inputs(); step(); end

    // reset in the middle of a wait clears everything
    for (int i = 0; i < 3; i++) begin idle_inputs(); mem_valid = 1; mem_mem_wr = 1; step(); end
    idle_inputs(); reset = 0; mem_valid = 1; mem_mem_wr = 1; step(); step();
    idle_inputs(); step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 299) != 0);
      id_valid        = $urandom_range(0, 1);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_valid        = ($urandom_range(0, 3) != 0);
      ex_rs           = 5'($urandom_range(0, 3));
      ex_rt           = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      ex_reg_wr       = $urandom_range(0, 1);
      ex_mem_to_reg   = $urandom_range(0, 1);
      ex_mdu_op       = ($urandom_range(0, 7) == 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_valid       = $urandom_range(0, 1);
      mem_reg_wr      = $urandom_range(0, 1);
      mem_mem_to_reg  = ($urandom_range(0, 2) == 0);
      mem_mem_wr      = ($urandom_range(0, 3) == 0);
      mem_rd          = 5'($urandom_range(0, 3));
      wb_valid        = $urandom_range(0, 1);
      wb_reg_wr       = $urandom_range(0, 1);
      wb_rd           = 5'($urandom_range(0, 3));
      dmem_ack        = $urandom_range(0, 1);
      step();
    end
    idle_inputs();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
